// File: rtl/bpu_if.sv
// Fetch/execute-facing signal bundle of the next-PC predictor.
// master = pipeline side, slave = bpu side.
interface bpu_if #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 32
) ();
    logic             inv_i;
    logic [XLEN-1:0]  pred_pc_i;
    logic [XLEN-1:0]  pred_npc_o;
    logic             pred_taken_o;
    logic             upd_valid_i;
    logic [XLEN-1:0]  upd_pc_i;
    logic             upd_is_branch_i;
    logic             upd_is_jal_i;
    logic             upd_is_jalr_i;
    logic             upd_is_trap_i;
    logic             upd_taken_i;
    logic [XLEN-1:0]  upd_target_i;
    logic [XLEN-1:0]  upd_pred_npc_i;
    logic             redirect_o;
    logic [XLEN-1:0]  redirect_pc_o;
    logic [CNT_W-1:0] mispred_cnt_o;

    modport master (
        output inv_i, pred_pc_i, upd_valid_i, upd_pc_i, upd_is_branch_i,
               upd_is_jal_i, upd_is_jalr_i, upd_is_trap_i, upd_taken_i,
               upd_target_i, upd_pred_npc_i,
        input  pred_npc_o, pred_taken_o, redirect_o, redirect_pc_o, mispred_cnt_o
    );

    modport slave (
        input  inv_i, pred_pc_i, upd_valid_i, upd_pc_i, upd_is_branch_i,
               upd_is_jal_i, upd_is_jalr_i, upd_is_trap_i, upd_taken_i,
               upd_target_i, upd_pred_npc_i,
        output pred_npc_o, pred_taken_o, redirect_o, redirect_pc_o, mispred_cnt_o
    );
endinterface

// File: rtl/bpu.sv
// Next-PC predictor: direct-mapped BTB with 2-bit counters, trained from
// execute, plus a registered one-cycle redirect and a mispredict counter.
module bpu #(
    parameter int XLEN    = 32,
    parameter int ENTRIES = 16,
    parameter int CNT_W   = 32
) (
    input  logic  clock,
    input  logic  reset,
    bpu_if.slave  bus
);
    localparam int IDX   = $clog2(ENTRIES);
    localparam int TAG_W = XLEN - IDX - 2;

    logic [ENTRIES-1:0] valid_q;
    logic [TAG_W-1:0]   tag_q    [ENTRIES];
    logic [XLEN-1:0]    target_q [ENTRIES];
    logic               cond_q   [ENTRIES];
    logic [1:0]         ctr_q    [ENTRIES];

    logic               redirect_q;
    logic [XLEN-1:0]    redirect_pc_q;
    logic [CNT_W-1:0]   cnt_q;

    logic [IDX-1:0]     p_idx, u_idx;
    logic [TAG_W-1:0]   p_tag, u_tag;
    logic               p_hit, p_taken;
    logic               u_hit, u_taken, mispredict;
    logic [XLEN-1:0]    actual;
    logic               alloc, tgt_we, ctr_we;
    logic [1:0]         ctr_d;

    // Low PC bits and the jal/jalr flags carry no information here.
    logic unused_ok;
    assign unused_ok = ^{bus.pred_pc_i[1:0], bus.upd_pc_i[1:0],
                         bus.upd_is_jal_i, bus.upd_is_jalr_i};

    assign p_idx = bus.pred_pc_i[IDX+1:2];
    assign p_tag = bus.pred_pc_i[XLEN-1:IDX+2];
    assign u_idx = bus.upd_pc_i[IDX+1:2];
    assign u_tag = bus.upd_pc_i[XLEN-1:IDX+2];

    always_comb begin
        p_hit   = valid_q[p_idx] && (tag_q[p_idx] == p_tag);
        p_taken = p_hit && (!cond_q[p_idx] || ctr_q[p_idx][1]);
        bus.pred_taken_o = p_taken;
        bus.pred_npc_o   = p_taken ? target_q[p_idx] : bus.pred_pc_i + XLEN'(4);
    end

    always_comb begin
        u_hit      = valid_q[u_idx] && (tag_q[u_idx] == u_tag);
        u_taken    = bus.upd_is_branch_i ? bus.upd_taken_i : 1'b1;
        actual     = u_taken ? bus.upd_target_i : bus.upd_pc_i + XLEN'(4);
        mispredict = bus.upd_valid_i && (actual != bus.upd_pred_npc_i);
        alloc      = 1'b0;
        tgt_we     = 1'b0;
        ctr_we     = 1'b0;
        ctr_d      = ctr_q[u_idx];
        if (bus.upd_valid_i && !bus.inv_i && !bus.upd_is_trap_i) begin
            if (u_hit) begin
                if (bus.upd_is_branch_i) begin
                    ctr_we = 1'b1;
                    tgt_we = u_taken;
                    if (u_taken)
                        ctr_d = (ctr_q[u_idx] == 2'd3) ? 2'd3 : ctr_q[u_idx] + 2'd1;
                    else
                        ctr_d = (ctr_q[u_idx] == 2'd0) ? 2'd0 : ctr_q[u_idx] - 2'd1;
                end else begin
                    tgt_we = 1'b1;
                end
            end else begin
                alloc = u_taken;
            end
        end
    end

    // Payload is meaningless while the entry is invalid, so it needs no reset.
    always_ff @(posedge clock) begin
        if (alloc) begin
            tag_q[u_idx]    <= u_tag;
            target_q[u_idx] <= bus.upd_target_i;
            cond_q[u_idx]   <= bus.upd_is_branch_i;
            ctr_q[u_idx]    <= 2'b10;
        end else begin
            if (tgt_we) target_q[u_idx] <= bus.upd_target_i;
            if (ctr_we) ctr_q[u_idx]    <= ctr_d;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            valid_q       <= '0;
            redirect_q    <= 1'b0;
            redirect_pc_q <= '0;
            cnt_q         <= '0;
        end else begin
            if (bus.inv_i)
                valid_q <= '0;
            else if (alloc)
                valid_q[u_idx] <= 1'b1;
            redirect_q <= mispredict;
            if (mispredict) begin
                redirect_pc_q <= actual;
                cnt_q         <= cnt_q + CNT_W'(1);
            end
        end
    end

    assign bus.redirect_o    = redirect_q;
    assign bus.redirect_pc_o = redirect_pc_q;
    assign bus.mispred_cnt_o = cnt_q;
endmodule

// File: tb/tb_bpu.sv
// Self-checking bench for bpu: directed scenarios, then randomized updates
// compared against a table-level reference model.
module tb_bpu;
    localparam int XLEN = 32;
    localparam int ENTRIES = 16;
    localparam int CNT_W = 32;
    localparam int K_BR = 0, K_JAL = 1, K_JALR = 2, K_TRAP = 3;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    bpu_if #(.XLEN(XLEN), .CNT_W(CNT_W)) bus ();

    bpu #(.XLEN(XLEN), .ENTRIES(ENTRIES), .CNT_W(CNT_W)) u_dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    int passed = 0;
    int total  = 0;

    // Reference model: one record per BTB slot, counters as plain ints.
    bit          m_valid [ENTRIES];
    logic [31:0] m_pc    [ENTRIES];
    logic [31:0] m_tgt   [ENTRIES];
    bit          m_cond  [ENTRIES];
    int          m_ctr   [ENTRIES];
    bit          m_redir;
    logic [31:0] m_rpc;
    logic [31:0] m_cnt;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    function automatic int slot(input logic [31:0] pc);
        return int'((pc / 4) % ENTRIES);
    endfunction

    function automatic bit m_hit(input logic [31:0] pc);
        int s = slot(pc);
        return m_valid[s] && ((m_pc[s] / (4 * ENTRIES)) == (pc / (4 * ENTRIES)));
    endfunction

    function automatic bit m_taken(input logic [31:0] pc);
        int s = slot(pc);
        return m_hit(pc) && (!m_cond[s] || m_ctr[s] >= 2);
    endfunction

    function automatic logic [31:0] m_npc(input logic [31:0] pc);
        return m_taken(pc) ? m_tgt[slot(pc)] : pc + 32'd4;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < ENTRIES; i++) m_valid[i] = 1'b0;
        m_redir = 1'b0;
        m_rpc   = '0;
        m_cnt   = '0;
    endtask

    task automatic do_reset();
        bus.inv_i = 0; bus.pred_pc_i = '0; bus.upd_valid_i = 0; bus.upd_pc_i = '0;
        bus.upd_is_branch_i = 0; bus.upd_is_jal_i = 0; bus.upd_is_jalr_i = 0;
        bus.upd_is_trap_i = 0; bus.upd_taken_i = 0; bus.upd_target_i = '0;
        bus.upd_pred_npc_i = '0;
        reset = 1'b1;
        model_reset();
        #2;
        check("rst_redirect", {31'd0, bus.redirect_o}, 32'd0);
        check("rst_cnt", bus.mispred_cnt_o, 32'd0);
        check("rst_rpc", bus.redirect_pc_o, 32'd0);
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
    endtask

    // One cycle: apply inputs at negedge, check lookup, clock it, check redirect.
    task automatic step(input bit inv, input logic [31:0] ppc, input bit v, input int kind,
                        input bit tk, input logic [31:0] upc, input logic [31:0] tgt,
                        input logic [31:0] pnpc);
        bit taken, mis;
        logic [31:0] actual;
        int s;
        @(negedge clock);
        bus.inv_i = inv; bus.pred_pc_i = ppc; bus.upd_valid_i = v; bus.upd_pc_i = upc;
        bus.upd_is_branch_i = (kind == K_BR); bus.upd_is_jal_i = (kind == K_JAL);
        bus.upd_is_jalr_i = (kind == K_JALR); bus.upd_is_trap_i = (kind == K_TRAP);
        bus.upd_taken_i = tk; bus.upd_target_i = tgt; bus.upd_pred_npc_i = pnpc;
        #1;
        check("pred_npc", bus.pred_npc_o, m_npc(ppc));
        check("pred_taken", {31'd0, bus.pred_taken_o}, {31'd0, m_taken(ppc)});

        taken  = (kind == K_BR) ? tk : 1'b1;
        actual = taken ? tgt : upc + 32'd4;
        mis    = v && (actual != pnpc);
        s      = slot(upc);
        if (v && !inv && kind != K_TRAP) begin
            if (m_hit(upc)) begin
                if (kind == K_BR) begin
                    m_ctr[s] = tk ? ((m_ctr[s] < 3) ? m_ctr[s] + 1 : 3)
                                  : ((m_ctr[s] > 0) ? m_ctr[s] - 1 : 0);
                    if (tk) m_tgt[s] = tgt;
                end else begin
                    m_tgt[s] = tgt;
                end
            end else if (taken) begin
                m_valid[s] = 1'b1; m_pc[s] = upc; m_tgt[s] = tgt;
                m_cond[s] = (kind == K_BR); m_ctr[s] = 2;
            end
        end
        if (inv) for (int i = 0; i < ENTRIES; i++) m_valid[i] = 1'b0;
        m_redir = mis;
        if (mis) begin
            m_rpc = actual;
            m_cnt = m_cnt + 32'd1;
        end

        @(posedge clock);
        #1;
        check("redirect", {31'd0, bus.redirect_o}, {31'd0, m_redir});
        check("redirect_pc", bus.redirect_pc_o, m_rpc);
        check("mispred_cnt", bus.mispred_cnt_o, m_cnt);
    endtask

    task automatic look(input logic [31:0] ppc);
        step(1'b0, ppc, 1'b0, K_BR, 1'b0, 32'h0, 32'h0, 32'h0);
    endtask

    initial begin
        logic [31:0] upc, ppc, tgt, pnpc;
        int kind;

        // Reset and cold lookup.
        do_reset();
        look(32'h8000_0000);
        check("cold_npc_const", m_npc(32'h8000_0000), 32'h8000_0004);

        // Taken branch allocates and redirects.
        step(0, 32'h8000_0010, 1, K_BR, 1, 32'h8000_0010, 32'h8000_0040, 32'h8000_0014);
        check("br_rpc_const", bus.redirect_pc_o, 32'h8000_0040);
        check("br_cnt_const", bus.mispred_cnt_o, 32'd1);
        look(32'h8000_0010);
        check("br_lookup_const", bus.pred_npc_o, 32'h8000_0040);

        // Not taken twice: 2->1->0.
        step(0, 32'h8000_0010, 1, K_BR, 0, 32'h8000_0010, 32'h8000_0040, 32'h8000_0040);
        check("nt1_rpc_const", bus.redirect_pc_o, 32'h8000_0014);
        step(0, 32'h8000_0010, 1, K_BR, 0, 32'h8000_0010, 32'h8000_0040, 32'h8000_0014);
        check("nt2_redirect_const", {31'd0, bus.redirect_o}, 32'd0);
        look(32'h8000_0010);
        check("nt_lookup_const", bus.pred_npc_o, 32'h8000_0014);

        // jalr retargeting.
        step(0, 32'h8000_0020, 1, K_JALR, 0, 32'h8000_0020, 32'h8000_0100, 32'h8000_0024);
        step(0, 32'h8000_0020, 1, K_JALR, 0, 32'h8000_0020, 32'h8000_0200, 32'h8000_0100);
        look(32'h8000_0020);
        check("jalr_lookup_const", bus.pred_npc_o, 32'h8000_0200);
        check("jalr_cnt_const", bus.mispred_cnt_o, 32'd4);

        // Trap: redirect, no allocation.
        step(0, 32'h8000_0030, 1, K_TRAP, 0, 32'h8000_0030, 32'h8000_1000, 32'h8000_0034);
        check("trap_rpc_const", bus.redirect_pc_o, 32'h8000_1000);
        look(32'h8000_0030);
        check("trap_noalloc_const", {31'd0, bus.pred_taken_o}, 32'd0);

        // Aliasing replacement.
        step(0, 32'h8000_0000, 1, K_BR, 1, 32'h8000_0000, 32'h8000_0080, 32'h8000_0004);
        step(0, 32'h8000_0000, 1, K_JAL, 0, 32'h8000_0040, 32'h8000_00c0, 32'h8000_0044);
        look(32'h8000_0000);
        check("alias_miss_const", bus.pred_npc_o, 32'h8000_0004);
        look(32'h8000_0040);

        // Invalidate together with an update; back-to-back pulses.
        step(1, 32'h8000_0050, 1, K_JAL, 0, 32'h8000_0050, 32'h8000_0500, 32'h8000_0054);
        check("inv_redirect_const", {31'd0, bus.redirect_o}, 32'd1);
        step(0, 32'h8000_0050, 1, K_JAL, 0, 32'h8000_0060, 32'h8000_0600, 32'h8000_0064);
        check("b2b_rpc_const", bus.redirect_pc_o, 32'h8000_0600);
        look(32'h8000_0040);
        look(32'h8000_0050);

        // Reset mid-operation drops the pending redirect.
        step(0, 32'h8000_0070, 1, K_JAL, 0, 32'h8000_0070, 32'h8000_0700, 32'h8000_0074);
        reset = 1'b1;
        #1;
        check("midrst_redirect", {31'd0, bus.redirect_o}, 32'd0);
        check("midrst_cnt", bus.mispred_cnt_o, 32'd0);
        do_reset();
        look(32'h8000_0060);

        // Randomized traffic over a small PC pool to force hits and aliasing.
        for (int n = 0; n < 400; n++) begin
            upc  = 32'h8000_0000 + ($urandom_range(0, 63) << 2);
            ppc  = ($urandom_range(0, 3) == 0) ? upc
                                               : 32'h8000_0000 + ($urandom_range(0, 63) << 2);
            tgt  = 32'h8000_0000 + ($urandom_range(0, 1023) << 2);
            kind = ($urandom_range(0, 9) < 6) ? K_BR : int'($urandom_range(1, 3));
            pnpc = ($urandom_range(0, 7) == 0) ? ($urandom() & 32'hffff_fffc) : m_npc(upc);
            step($urandom_range(0, 24) == 0, ppc, $urandom_range(0, 3) != 0, kind,
                 $urandom_range(0, 1) == 1, upc, tgt, pnpc);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end
endmodule
